// File: rtl/crc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | crc_pkg : shared types, polynomial constants and bit-step helper  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam logic [15:0] CRC16_USB_POLY = 16'h8005;
    localparam logic [4:0]  CRC5_USB_POLY  = 5'h05;
    localparam int          CRC_MAX_W      = 64;

    // One MSB-first division step for any CRC width up to CRC_MAX_W.
    function automatic logic [CRC_MAX_W-1:0] crc_step(
        input logic [CRC_MAX_W-1:0] rem,
        input logic                 din,
        input logic [CRC_MAX_W-1:0] poly,
        input int unsigned          width
    );
        logic                 fb;
        logic [CRC_MAX_W-1:0] mask;
        mask = {CRC_MAX_W{1'b1}} >> (CRC_MAX_W - width);
        fb   = rem[width-1] ^ din;
        return ((rem << 1) ^ (fb ? poly : '0)) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc_stream_checker_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | crc_stream_checker_if : valid/ready beat stream into the checker  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface crc_stream_checker_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;

    modport master (output in_valid, output in_data, output in_last, input  in_ready);
    modport slave  (input  in_valid, input  in_data, input  in_last, output in_ready);
endinterface
`default_nettype wire

// File: rtl/crc_beat_update.sv
`default_nettype none
// +------------------------------------------------------------------+
// | crc_beat_update : folds one DATA_W-bit beat into the remainder    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module crc_beat_update
    import crc_pkg::*;
#(
    parameter int              DATA_W = 8,
    parameter int              CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY  = CRC16_USB_POLY
) (
    input  logic [CRC_W-1:0]  rem_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [CRC_W-1:0]  rem_out
);
    logic [CRC_W-1:0] w_rem;

    always_comb begin
        w_rem = rem_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            w_rem = CRC_W'(crc_step(CRC_MAX_W'(w_rem), data_in[i],
                                    CRC_MAX_W'(POLY), CRC_W));
        end
        rem_out = w_rem;
    end
endmodule
`default_nettype wire

// File: rtl/crc_stream_checker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | crc_stream_checker : per-frame CRC and length check on a stream   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module crc_stream_checker
    import crc_pkg::*;
#(
    parameter int               DATA_W    = 8,
    parameter int               CRC_W     = 16,
    parameter logic [CRC_W-1:0] POLY      = CRC16_USB_POLY,
    parameter logic [CRC_W-1:0] INIT      = '0,
    parameter int               MAX_BEATS = 64,
    localparam int              CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    crc_stream_checker_if.slave stream,
    output logic                done,
    output logic                crc_valid,
    output logic                crc_error,
    output logic                len_error,
    output logic [CNT_W-1:0]    beat_count,
    output logic [CRC_W-1:0]    remainder
);
    localparam logic [CNT_W-1:0] C_MAX_BEATS = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] C_MIN_BEATS = CNT_W'(CRC_W / DATA_W + 1);

    state_t           r_state, w_state_nxt;
    logic [CRC_W-1:0] r_rem, w_rem_nxt, w_rem_base, w_rem_upd;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_base, w_cnt_inc;
    logic             r_ovf, w_ovf_nxt;
    logic             w_accept, w_load, w_at_max, w_len_err;
    logic             r_crc_valid, r_crc_error, r_len_error;

    assign stream.in_ready = (r_state != REPORT);
    assign w_accept        = stream.in_valid && stream.in_ready;

    // A new frame always starts from the seed, while the registers keep
    // showing the previous frame until its first beat arrives.
    assign w_rem_base = (r_state == IDLE) ? INIT : r_rem;
    assign w_cnt_base = (r_state == IDLE) ? '0   : r_cnt;
    assign w_at_max   = (w_cnt_base == C_MAX_BEATS);
    assign w_cnt_inc  = w_at_max ? C_MAX_BEATS : w_cnt_base + CNT_W'(1);

    crc_beat_update #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W),
        .POLY   (POLY)
    ) u_beat_update (
        .rem_in  (w_rem_base),
        .data_in (stream.in_data),
        .rem_out (w_rem_upd)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_rem_nxt = w_rem_upd;
                    w_cnt_nxt = w_cnt_inc;
                    w_ovf_nxt = 1'b0;
                    if (stream.in_last) begin
                        w_state_nxt = REPORT;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    w_rem_nxt = w_rem_upd;
                    w_cnt_nxt = w_cnt_inc;
                    if (stream.in_last) begin
                        w_state_nxt = REPORT;
                        w_load      = 1'b1;
                    end else if (w_at_max) begin
                        w_ovf_nxt   = 1'b1;
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_accept && stream.in_last) begin
                    w_state_nxt = REPORT;
                    w_load      = 1'b1;
                end
            end
            REPORT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // A last beat arriving when the count is already saturated is one too many.
        w_len_err = w_ovf_nxt || ((r_state != IDLE) && w_at_max) || (w_cnt_nxt < C_MIN_BEATS);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_rem   <= INIT;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else if (clear) begin
            r_state <= IDLE;
            r_rem   <= INIT;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_crc_valid <= 1'b0;
            r_crc_error <= 1'b0;
            r_len_error <= 1'b0;
        end else if (clear) begin
            r_crc_valid <= 1'b0;
            r_crc_error <= 1'b0;
            r_len_error <= 1'b0;
        end else if (w_load) begin
            r_len_error <= w_len_err;
            r_crc_valid <= !w_len_err && (w_rem_nxt == '0);
            r_crc_error <= !w_len_err && (w_rem_nxt != '0);
        end
    end

    assign done       = (r_state == REPORT);
    assign crc_valid  = r_crc_valid;
    assign crc_error  = r_crc_error;
    assign len_error  = r_len_error;
    assign beat_count = r_cnt;
    assign remainder  = r_rem;
endmodule
`default_nettype wire

// File: tb/tb_crc_stream_checker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_crc_stream_checker : vector table + scoreboard bench           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_crc_stream_checker;
    localparam int CNT_W = 7;

    logic             clk;
    logic             n_rst;
    logic             clear;
    logic             done, crc_valid, crc_error, len_error;
    logic [CNT_W-1:0] beat_count;
    logic [15:0]      remainder;

    crc_stream_checker_if #(.DATA_W(8)) bus ();

    crc_stream_checker #(
        .DATA_W    (8),
        .CRC_W     (16),
        .POLY      (16'h8005),
        .INIT      (16'h0000),
        .MAX_BEATS (64)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .stream     (bus),
        .done       (done),
        .crc_valid  (crc_valid),
        .crc_error  (crc_error),
        .len_error  (len_error),
        .beat_count (beat_count),
        .remainder  (remainder)
    );

    typedef struct {
        bit          v;
        bit          e;
        bit          l;
        bit          chk_rem;
        logic [15:0] rem;
        int          cnt;
    } exp_t;

    typedef struct {
        logic [0:15][7:0] d;
        int               len;
        exp_t             exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   first_acc_cyc, last_acc_cyc, beats_acc;
    bit   acc_prev, done_prev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic exp_t mk(bit v, bit e, bit l, bit chk, logic [15:0] rem, int cnt);
        exp_t x;
        x.v = v; x.e = e; x.l = l; x.chk_rem = chk; x.rem = rem; x.cnt = cnt;
        return x;
    endfunction

    function automatic logic [15:0] model_crc(input logic [7:0] q[$]);
        logic [15:0] r;
        logic        fb;
        r = 16'h0000;
        foreach (q[k]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = r[15] ^ q[k][b];
                r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic add_vec(input logic [127:0] d, input int len, input exp_t e);
        vec_t v;
        v.d = d; v.len = len; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic send_beat(input logic [7:0] d, input bit last);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: in_ready stayed 0, expected 1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        beats_acc++;
        last_acc_cyc = cyc;
    endtask

    task automatic send_frame(input logic [7:0] q[$], input logic [31:0] gaps, input exp_t e);
        for (int i = 0; i < q.size(); i++) begin
            if (i < 32 && gaps[i]) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send_beat(q[i], i == q.size() - 1);
            if (i == 0) first_acc_cyc = last_acc_cyc;
        end
        sb.push_back(e);
    endtask

    // Scoreboard and handshake monitor, sampling on the falling edge.
    initial begin
        exp_t e;
        acc_prev  = 1'b0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done || acc_prev) check("done_latency", done, acc_prev);
            if (done) begin
                check("ready_in_done", bus.in_ready, 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1, expected no frame report");
                end else begin
                    e = sb.pop_front();
                    check("crc_valid", crc_valid, e.v);
                    check("crc_error", crc_error, e.e);
                    check("len_error", len_error, e.l);
                    check("beat_count", beat_count, e.cnt);
                    if (e.chk_rem) check("remainder", remainder, e.rem);
                    check("one_status", 32'(crc_valid) + 32'(crc_error) + 32'(len_error), 1);
                end
            end
            if (done_prev) check("ready_after_done", bus.in_ready, 1);
            acc_prev  = n_rst && !clear && bus.in_valid && bus.in_ready && bus.in_last;
            done_prev = done;
        end
    end

    initial begin
        logic [7:0]  q[$];
        logic [15:0] c;
        logic [31:0] gaps;
        int          prev_last;

        n_rst = 1'b1;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        beats_acc    = 0;
        #1 n_rst = 1'b0;
        #2;
        check("rst_done", done, 0);
        check("rst_crc_valid", crc_valid, 0);
        check("rst_crc_error", crc_error, 0);
        check("rst_len_error", len_error, 0);
        check("rst_beat_count", beat_count, 0);
        check("rst_remainder", remainder, 16'h0000);
        check("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        add_vec({72'h313233343536373839, 16'hFEE8, 40'h0}, 11, mk(1, 0, 0, 1, 16'h0000, 11));
        add_vec({72'h313233343536373839, 16'hFEE9, 40'h0}, 11, mk(0, 1, 0, 1, 16'h8005, 11));
        add_vec({16'h0000, 112'h0},                          2, mk(0, 0, 1, 1, 16'h0000, 2));
        add_vec({8'h31, 120'h0},                             1, mk(0, 0, 1, 0, 16'h0000, 1));
        add_vec({24'h000000, 104'h0},                        3, mk(1, 0, 0, 1, 16'h0000, 3));
        add_vec({24'h000001, 104'h0},                        3, mk(0, 1, 0, 1, 16'h8005, 3));

        // Back-to-back frames: each must start exactly one bubble after the last.
        for (int i = 0; i < vecs.size(); i++) begin
            q.delete();
            for (int j = 0; j < vecs[i].len; j++) q.push_back(vecs[i].d[j]);
            prev_last = last_acc_cyc;
            send_frame(q, 32'h0, vecs[i].exp);
            if (i > 0) check("b2b_bubble", first_acc_cyc - prev_last, 2);
        end

        q.delete();
        for (int j = 0; j < 11; j++) q.push_back(vecs[0].d[j]);
        gaps = '0;
        while ($countones(gaps) < 3) gaps[$urandom_range(10, 1)] = 1'b1;
        send_frame(q, gaps, mk(1, 0, 0, 1, 16'h0000, 11));
        repeat (3) @(posedge clk);
        #1;
        check("hold_crc_valid", crc_valid, 1);
        check("hold_beat_count", beat_count, 11);

        q.delete();
        for (int j = 0; j < 62; j++) q.push_back(8'($urandom));
        c = model_crc(q);
        q.push_back(c[15:8]);
        q.push_back(c[7:0]);
        send_frame(q, 32'h0, mk(1, 0, 0, 1, 16'h0000, 64));

        q.delete();
        for (int j = 0; j < 63; j++) q.push_back(8'($urandom));
        c = model_crc(q);
        q.push_back(c[15:8]);
        q.push_back(c[7:0]);
        send_frame(q, 32'h0, mk(0, 0, 1, 0, 16'h0000, 64));

        q.delete();
        for (int j = 0; j < 70; j++) q.push_back(8'($urandom));
        beats_acc = 0;
        send_frame(q, 32'h0, mk(0, 0, 1, 0, 16'h0000, 64));
        check("long_beats_consumed", beats_acc, 70);

        // Abort at beat 5; the aborted frame must never report.
        q.delete();
        for (int j = 0; j < 11; j++) q.push_back(vecs[0].d[j]);
        for (int j = 0; j < 4; j++) send_beat(q[j], 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = q[4];
        clear        = 1'b1;
        @(posedge clk);
        #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_beat_count", beat_count, 0);
        check("clr_len_error", len_error, 0);
        check("clr_remainder", remainder, 16'h0000);
        check("clr_done", done, 0);
        send_frame(q, 32'h0, mk(1, 0, 0, 1, 16'h0000, 11));

        @(posedge clk);
        #1;
        for (int j = 0; j < 4; j++) send_beat(q[j], 1'b0);
        bus.in_valid = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        check("arst_crc_valid", crc_valid, 0);
        check("arst_beat_count", beat_count, 0);
        check("arst_remainder", remainder, 16'h0000);
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_done", done, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        send_frame(q, 32'h0, mk(1, 0, 0, 1, 16'h0000, 11));

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
